// File: rtl/tspi_pkg.sv
// Shared TSPI definitions: target FSM states and the defaults that both the
// target and any master-side driver agree on.
package tspi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } tspi_state_e;

    localparam int unsigned TspiFrameBits  = 8;
    localparam logic [7:0]  TspiFillByte   = 8'hFF;
    localparam int unsigned TspiSyncStages = 2;

    // Mode 0: sclk idles low, data sampled on the rising edge, changed on falling.
    localparam logic TspiCpol = 1'b0;
    localparam logic TspiCpha = 1'b0;

    // Shortest sclk phase (in system clocks) the oversampling target can follow.
    function automatic int unsigned tspi_min_phase_cycles(input int unsigned sync_stages);
        return sync_stages + 2;
    endfunction

endpackage

// File: rtl/tspi_if.sv
// Bundle of the SPI pins and the RX/TX byte streams of the TSPI target.
interface tspi_if
    import tspi_pkg::*;
#(
    parameter int unsigned FrameBits = TspiFrameBits
) ();

    logic                 spi_sclk_i;
    logic                 spi_cs_ni;
    logic                 spi_mosi_i;
    logic                 spi_miso_o;
    logic                 spi_miso_oe_o;
    logic [FrameBits-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 rx_ready_i;
    logic [FrameBits-1:0] tx_data_i;
    logic                 tx_valid_i;
    logic                 tx_ready_o;
    logic                 rx_overflow_o;
    logic                 tx_underrun_o;
    logic                 busy_o;

    // Target side: the tspi_target itself.
    modport slave (
        input  spi_sclk_i, spi_cs_ni, spi_mosi_i, rx_ready_i, tx_data_i, tx_valid_i,
        output spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
               rx_overflow_o, tx_underrun_o, busy_o
    );

    // Far side: SPI master plus the stream producer/consumer.
    modport master (
        output spi_sclk_i, spi_cs_ni, spi_mosi_i, rx_ready_i, tx_data_i, tx_valid_i,
        input  spi_miso_o, spi_miso_oe_o, rx_data_o, rx_valid_o, tx_ready_o,
               rx_overflow_o, tx_underrun_o, busy_o
    );

endinterface

// File: rtl/tspi_sync_edge.sv
// Synchroniser chain plus one delay flop; yields the synchronised level and
// single-cycle rise/fall strobes for an asynchronous input.
module tspi_sync_edge
    import tspi_pkg::*;
#(
    parameter int unsigned SyncStages = TspiSyncStages,
    parameter logic        ResetVal   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SyncStages-1:0] sync_q;
    logic                  dly_q;

    // Metastability chain followed by the edge-detect delay flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SyncStages{ResetVal}};
            dly_q  <= ResetVal;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], sig_i};
            dly_q  <= sync_q[SyncStages-1];
        end
    end

    assign level_o = sync_q[SyncStages-1];
    assign rise_o  = sync_q[SyncStages-1] & ~dly_q;
    assign fall_o  = ~sync_q[SyncStages-1] & dly_q;

endmodule

// File: rtl/tspi_target.sv
// SPI mode-0 target that oversamples sclk/cs_n/mosi on the system clock,
// deserialises MOSI into an RX stream and serialises a TX stream onto MISO.
module tspi_target
    import tspi_pkg::*;
#(
    parameter int unsigned          SyncStages = TspiSyncStages,
    parameter int unsigned          FrameBits  = TspiFrameBits,
    parameter logic [FrameBits-1:0] FillByte   = TspiFillByte
) (
    input logic   clk_i,
    input logic   rst_ni,
    tspi_if.slave bus
);

    localparam int unsigned          CntW    = (FrameBits > 1) ? $clog2(FrameBits) : 1;
    localparam logic [CntW-1:0]      LastBit = CntW'(FrameBits - 1);

    logic                  sclk_level, sclk_rise, sclk_fall;
    logic                  cs_level, cs_rise, cs_fall;
    logic [SyncStages-1:0] mosi_sync_q;
    logic                  mosi_sync;

    tspi_state_e           state_q;
    logic [CntW-1:0]       bit_cnt_q;
    logic [FrameBits-1:0]  rx_shift_q;
    logic [FrameBits-1:0]  tx_shift_q;
    logic [FrameBits-1:0]  tx_hold_q;
    logic                  tx_full_q;
    logic                  fill_pend_q;
    logic                  frame_done_q;
    logic                  miso_q;
    logic                  miso_oe_q;
    logic                  underrun_q;
    logic [FrameBits-1:0]  rx_data_q;
    logic                  rx_valid_q;
    logic                  overflow_q;

    logic                  tx_write;
    logic                  load_entry;
    logic                  load_bound;
    logic                  tx_take;
    logic                  unused_levels;

    tspi_sync_edge #(
        .SyncStages (SyncStages),
        .ResetVal   (TspiCpol)
    ) u_sync_sclk (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .sig_i   (bus.spi_sclk_i),
        .level_o (sclk_level),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    tspi_sync_edge #(
        .SyncStages (SyncStages),
        .ResetVal   (1'b1)
    ) u_sync_cs (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .sig_i   (bus.spi_cs_ni),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    // Only the strobes carry timing here; the synchronised levels are not needed.
    assign unused_levels = sclk_level ^ cs_level;

    // MOSI synchroniser, same depth so it lines up with the sclk strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], bus.spi_mosi_i};
        end
    end

    assign mosi_sync = mosi_sync_q[SyncStages-1];

    // TX shift register is (re)loaded on selection and at each frame boundary
    // (falling sclk after the last bit). cs_rise wins over a same-cycle strobe.
    assign tx_write   = bus.tx_valid_i & ~tx_full_q;
    assign load_entry = (state_q == IDLE) & cs_fall;
    assign load_bound = (state_q == ACTIVE) & ~cs_rise & ~sclk_rise & sclk_fall &
                        (bit_cnt_q == '0);
    assign tx_take    = (load_entry | load_bound) & tx_full_q;

    // TX holding register: a load consumes old content, a write refills it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_hold_q <= '0;
            tx_full_q <= 1'b0;
        end else if (tx_write) begin
            tx_hold_q <= bus.tx_data_i;
            tx_full_q <= 1'b1;
        end else if (tx_take) begin
            tx_full_q <= 1'b0;
        end
    end

    // Selection FSM with bit counter, shift registers and registered MISO.
    // A FillByte loaded at a frame boundary only counts as an underrun once the
    // master actually clocks it out, so the trailing falling edge of the last
    // frame in a transaction never reports a spurious underrun.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            fill_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    if (cs_fall) begin
                        state_q     <= ACTIVE;
                        bit_cnt_q   <= '0;
                        miso_oe_q   <= 1'b1;
                        fill_pend_q <= 1'b0;
                        tx_shift_q  <= tx_full_q ? tx_hold_q : FillByte;
                        underrun_q  <= ~tx_full_q;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q     <= IDLE;
                        bit_cnt_q   <= '0;
                        fill_pend_q <= 1'b0;
                        miso_q      <= 1'b0;
                        miso_oe_q   <= 1'b0;
                    end else begin
                        miso_q <= tx_shift_q[FrameBits-1];
                        if (sclk_rise) begin
                            rx_shift_q <= {rx_shift_q[FrameBits-2:0], mosi_sync};
                            if ((bit_cnt_q == '0) && fill_pend_q) begin
                                underrun_q  <= 1'b1;
                                fill_pend_q <= 1'b0;
                            end
                            if (bit_cnt_q == LastBit) begin
                                bit_cnt_q    <= '0;
                                frame_done_q <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end else if (sclk_fall) begin
                            if (bit_cnt_q != '0) begin
                                tx_shift_q <= {tx_shift_q[FrameBits-2:0], 1'b0};
                            end else begin
                                tx_shift_q  <= tx_full_q ? tx_hold_q : FillByte;
                                fill_pend_q <= ~tx_full_q;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // RX output register: commit a completed frame or flag it as dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (frame_done_q) begin
                if (!rx_valid_q || bus.rx_ready_i) begin
                    rx_data_q  <= rx_shift_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
            end else if (rx_valid_q && bus.rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign bus.spi_miso_o    = miso_q;
    assign bus.spi_miso_oe_o = miso_oe_q;
    assign bus.rx_data_o     = rx_data_q;
    assign bus.rx_valid_o    = rx_valid_q;
    assign bus.tx_ready_o    = ~tx_full_q;
    assign bus.rx_overflow_o = overflow_q;
    assign bus.tx_underrun_o = underrun_q;
    assign bus.busy_o        = (state_q == ACTIVE);

endmodule

// File: tb/tb_tspi_target.sv
// Directed bench for tspi_target: a mode-0 master, a TX feeder and an RX sink.
module tb_tspi_target;
    import tspi_pkg::*;

    localparam int Half = int'(tspi_min_phase_cycles(TspiSyncStages));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_unr = 0;
    int   n_ovf = 0;
    logic [7:0] rxq[$];

    tspi_if #(.FrameBits(8)) bus ();

    tspi_target #(
        .SyncStages (TspiSyncStages),
        .FrameBits  (8),
        .FillByte   (8'hFF)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Pulse counters and RX sink log, all sampled on the active edge.
    always @(posedge clk) begin
        if (bus.tx_underrun_o) n_unr <= n_unr + 1;
        if (bus.rx_overflow_o) n_ovf <= n_ovf + 1;
        if (bus.rx_valid_o && bus.rx_ready_i) rxq.push_back(bus.rx_data_o);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic cs_lo();
        bus.spi_cs_ni = 1'b0;
        cyc(6);
    endtask

    task automatic cs_hi();
        cyc(6);
        bus.spi_cs_ni = 1'b1;
        cyc(6);
    endtask

    task automatic tx_push(input logic [7:0] b);
        bus.tx_data_i  = b;
        bus.tx_valid_i = 1'b1;
        cyc(1);
        bus.tx_valid_i = 1'b0;
    endtask

    task automatic rx_accept();
        bus.rx_ready_i = 1'b1;
        cyc(1);
        bus.rx_ready_i = 1'b0;
        check_vec("rx_drop", 8'(bus.rx_valid_o), 8'd0);
    endtask

    // Mode-0 master: drive MOSI with sclk low, sample MISO at the rising edge.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input int half,
                            input bit chk_lat, output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.spi_mosi_i = mo[i];
            cyc(half);
            bus.spi_sclk_i = 1'b1;
            mi = {mi[6:0], bus.spi_miso_o};
            if (chk_lat && i == 0) begin
                cyc(3);
                check_vec("rx_lat_early", 8'(bus.rx_valid_o), 8'd0);
                cyc(1);
                check_vec("rx_lat", 8'(bus.rx_valid_o), 8'd1);
                cyc(half - 4);
            end else begin
                cyc(half);
            end
            bus.spi_sclk_i = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] mis[4];
        int ubase, obase, qbase;

        bus.spi_sclk_i = TspiCpol;
        bus.spi_cs_ni  = 1'b1;
        bus.spi_mosi_i = 1'b0;
        bus.rx_ready_i = 1'b0;
        bus.tx_data_i  = '0;
        bus.tx_valid_i = 1'b0;

        // Reset values
        cyc(3);
        check_vec("rst_miso", 8'(bus.spi_miso_o), 8'd0);
        check_vec("rst_oe", 8'(bus.spi_miso_oe_o), 8'd0);
        check_vec("rst_rxd", bus.rx_data_o, 8'h00);
        check_vec("rst_rxv", 8'(bus.rx_valid_o), 8'd0);
        check_vec("rst_txr", 8'(bus.tx_ready_o), 8'd1);
        check_vec("rst_ovf", 8'(bus.rx_overflow_o), 8'd0);
        check_vec("rst_unr", 8'(bus.tx_underrun_o), 8'd0);
        check_vec("rst_busy", 8'(bus.busy_o), 8'd0);
        rst_n = 1'b1;
        cyc(3);

        // 1: preloaded A5 out, 3C in at clk/8, with RX latency check
        tx_push(8'hA5);
        check_vec("t1_txr_full", 8'(bus.tx_ready_o), 8'd0);
        cs_lo();
        check_vec("t1_txr_load", 8'(bus.tx_ready_o), 8'd1);
        check_vec("t1_busy", 8'(bus.busy_o), 8'd1);
        spi_xfer(8'h3C, 8, Half, 1'b1, mi);
        cs_hi();
        check_vec("t1_miso", mi, 8'hA5);
        check_vec("t1_rxd", bus.rx_data_o, 8'h3C);
        rx_accept();

        // 2: nothing to send -> FillByte and exactly one underrun
        ubase = n_unr;
        cs_lo();
        spi_xfer(8'h00, 8, Half + 2, 1'b0, mi);
        cs_hi();
        check_vec("t2_miso", mi, 8'hFF);
        check_vec("t2_unr", 8'(n_unr - ubase), 8'd1);
        check_vec("t2_rxd", bus.rx_data_o, 8'h00);
        rx_accept();

        // 3: two frames without consuming -> first kept, one overflow
        obase = n_ovf;
        cs_lo();
        spi_xfer(8'h11, 8, Half, 1'b0, mi);
        check_vec("t3_ovf_mid", 8'(n_ovf - obase), 8'd0);
        spi_xfer(8'h22, 8, Half, 1'b0, mi);
        cs_hi();
        check_vec("t3_rxd", bus.rx_data_o, 8'h11);
        check_vec("t3_rxv", 8'(bus.rx_valid_o), 8'd1);
        check_vec("t3_ovf", 8'(n_ovf - obase), 8'd1);
        rx_accept();

        // 4: 4-byte burst, TX fed just in time, RX drained continuously
        ubase = n_unr;
        obase = n_ovf;
        qbase = rxq.size();
        bus.rx_ready_i = 1'b1;
        tx_push(8'hF0);
        cs_lo();
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    spi_xfer(8'(k + 1), 8, Half, 1'b0, mis[k]);
                end
            end
            begin
                for (int k = 1; k < 4; k++) begin
                    int cnt = 0;
                    while (!bus.tx_ready_o && cnt < 2000) begin
                        cyc(1);
                        cnt++;
                    end
                    check_vec("t4_feed_rdy", 8'(bus.tx_ready_o), 8'd1);
                    tx_push(8'(8'hF0 + k));
                end
            end
        join
        cs_hi();
        bus.rx_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_vec($sformatf("t4_miso%0d", k), mis[k], 8'(8'hF0 + k));
            check_vec($sformatf("t4_rx%0d", k),
                      (rxq.size() > qbase + k) ? rxq[qbase + k] : 8'hXX, 8'(k + 1));
        end
        check_vec("t4_rxcnt", 8'(rxq.size() - qbase), 8'd4);
        check_vec("t4_unr", 8'(n_unr - ubase), 8'd0);
        check_vec("t4_ovf", 8'(n_ovf - obase), 8'd0);

        // 5: cs_n raised after 5 bits of C3, then a clean 5A frame
        obase = n_ovf;
        cs_lo();
        check_vec("t5_oe_on", 8'(bus.spi_miso_oe_o), 8'd1);
        spi_xfer(8'hC3, 5, Half, 1'b0, mi);
        cs_hi();
        check_vec("t5_busy", 8'(bus.busy_o), 8'd0);
        check_vec("t5_oe_off", 8'(bus.spi_miso_oe_o), 8'd0);
        check_vec("t5_miso_off", 8'(bus.spi_miso_o), 8'd0);
        check_vec("t5_rxv", 8'(bus.rx_valid_o), 8'd0);
        cs_lo();
        spi_xfer(8'h5A, 8, Half, 1'b0, mi);
        cs_hi();
        check_vec("t5_rxd", bus.rx_data_o, 8'h5A);
        check_vec("t5_rxv2", 8'(bus.rx_valid_o), 8'd1);
        check_vec("t5_ovf", 8'(n_ovf - obase), 8'd0);

        // 6: asynchronous reset mid-frame, then a full 99 exchange
        cs_lo();
        tx_push(8'h66);
        check_vec("t6_txr_full", 8'(bus.tx_ready_o), 8'd0);
        check_vec("t6_rxv_pre", 8'(bus.rx_valid_o), 8'd1);
        spi_xfer(8'hE7, 3, Half, 1'b0, mi);
        rst_n = 1'b0;
        #2;
        check_vec("t6_busy", 8'(bus.busy_o), 8'd0);
        check_vec("t6_oe", 8'(bus.spi_miso_oe_o), 8'd0);
        check_vec("t6_miso", 8'(bus.spi_miso_o), 8'd0);
        check_vec("t6_rxv", 8'(bus.rx_valid_o), 8'd0);
        check_vec("t6_rxd", bus.rx_data_o, 8'h00);
        check_vec("t6_txr", 8'(bus.tx_ready_o), 8'd1);
        bus.spi_cs_ni = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(4);
        ubase = n_unr;
        tx_push(8'h99);
        cs_lo();
        spi_xfer(8'h99, 8, Half + 1, 1'b0, mi);
        cs_hi();
        check_vec("t6_miso99", mi, 8'h99);
        check_vec("t6_rxd99", bus.rx_data_o, 8'h99);
        check_vec("t6_rxv99", 8'(bus.rx_valid_o), 8'd1);
        check_vec("t6_unr", 8'(n_unr - ubase), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
